// File: rtl/muldiv_sequencer.sv
// Control sequencer for an iterative multiply/divide unit.
// Accepts one mul/div instruction from execute, pulses dp_load, then
// issues a fixed number of dp_step cycles. It then presents done until
// the pipeline is free to take the result.
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] muldiv_funct,
    input  logic       divisor_zero,
    input  logic       clear,
    input  logic       hold_result,
    output logic       wait_result,
    output logic       dp_load,
    output logic       dp_step,
    output logic       dp_signed,
    output logic [1:0] dp_accum,
    output logic       done,
    output logic       div_zero,
    output logic [5:0] count
);

    localparam logic [2:0] FN_NONE  = 3'd0;
    localparam logic [2:0] FN_MULT  = 3'd1;
    localparam logic [2:0] FN_MULTU = 3'd2;
    localparam logic [2:0] FN_MADD  = 3'd3;
    localparam logic [2:0] FN_MADDU = 3'd4;
    localparam logic [2:0] FN_MSUB  = 3'd5;
    localparam logic [2:0] FN_DIV   = 3'd6;
    localparam logic [2:0] FN_DIVU  = 3'd7;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_ADD  = 2'b01;
    localparam logic [1:0] ACC_SUB  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [5:0] count_reg, count_next;
    logic       signed_reg, signed_next;
    logic [1:0] accum_reg, accum_next;
    logic       done_reg, done_next;
    logic       div_zero_reg, div_zero_next;
    logic       accept;

    // Accept is gated by reset so dp_load/wait_result drop the instant reset asserts.
    assign accept = reset && (state_reg == IDLE) && start && !clear
                    && (muldiv_funct != FN_NONE);

    // State register and latched operation attributes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= 6'd0;
            signed_reg   <= 1'b0;
            accum_reg    <= ACC_NONE;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            signed_reg   <= signed_next;
            accum_reg    <= accum_next;
            done_reg     <= done_next;
            div_zero_reg <= div_zero_next;
        end
    end

    // Next-state logic and the combinational datapath strobes.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        signed_next   = signed_reg;
        accum_next    = accum_reg;
        div_zero_next = div_zero_reg;
        dp_load       = 1'b0;
        dp_step       = 1'b0;
        wait_result   = 1'b0;

        if (clear) begin
            // A bubble/nullify aborts everything, including a pending accept or hold.
            state_next    = IDLE;
            count_next    = 6'd0;
            signed_next   = 1'b0;
            accum_next    = ACC_NONE;
            div_zero_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dp_load     = 1'b1;
                        wait_result = 1'b1;
                        signed_next = (muldiv_funct == FN_MULT) || (muldiv_funct == FN_MADD)
                                   || (muldiv_funct == FN_MSUB) || (muldiv_funct == FN_DIV);
                        if ((muldiv_funct == FN_MADD) || (muldiv_funct == FN_MADDU))
                            accum_next = ACC_ADD;
                        else if (muldiv_funct == FN_MSUB)
                            accum_next = ACC_SUB;
                        else
                            accum_next = ACC_NONE;
                        if ((muldiv_funct == FN_DIV) || (muldiv_funct == FN_DIVU)) begin
                            if (divisor_zero) begin
                                // Nothing to iterate: report the fault straight away.
                                state_next    = DONE;
                                count_next    = 6'd0;
                                div_zero_next = 1'b1;
                            end else begin
                                state_next = DIV;
                                count_next = 6'(DIV_CYCLES - 1);
                            end
                        end else begin
                            state_next = MUL;
                            count_next = 6'(MUL_CYCLES - 1);
                        end
                    end
                end
                MUL, DIV: begin
                    // hold_result is deliberately ignored while iterating.
                    dp_step     = 1'b1;
                    wait_result = 1'b1;
                    if (count_reg != 6'd0)
                        count_next = count_reg - 6'd1;
                    else
                        state_next = DONE;
                end
                DONE: begin
                    if (!hold_result) begin
                        state_next    = IDLE;
                        div_zero_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        done_next = (state_next == DONE);
    end

    assign dp_signed = signed_reg;
    assign dp_accum  = accum_reg;
    assign done      = done_reg;
    assign div_zero  = div_zero_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. Each stimulus cycle pushes the
// hand-computed output bundle for that cycle; a separate monitor pops
// and compares on every falling edge.
module tb_muldiv_sequencer;

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_MULT  = 3'd1;
    localparam logic [2:0] F_MULTU = 3'd2;
    localparam logic [2:0] F_MADD  = 3'd3;
    localparam logic [2:0] F_MSUB  = 3'd5;
    localparam logic [2:0] F_DIV   = 3'd6;
    localparam logic [2:0] F_DIVU  = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] muldiv_funct;
    logic       divisor_zero;
    logic       clear;
    logic       hold_result;
    logic       wait_result;
    logic       dp_load;
    logic       dp_step;
    logic       dp_signed;
    logic [1:0] dp_accum;
    logic       done;
    logic       div_zero;
    logic [5:0] count;

    typedef struct packed {
        logic       w;
        logic       load;
        logic       step;
        logic       sgn;
        logic [1:0] acc;
        logic       dn;
        logic       dz;
        logic [5:0] cnt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    obs_t  act;

    always #5 clk = ~clk;

    muldiv_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .muldiv_funct (muldiv_funct),
        .divisor_zero (divisor_zero),
        .clear        (clear),
        .hold_result  (hold_result),
        .wait_result  (wait_result),
        .dp_load      (dp_load),
        .dp_step      (dp_step),
        .dp_signed    (dp_signed),
        .dp_accum     (dp_accum),
        .done         (done),
        .div_zero     (div_zero),
        .count        (count)
    );

    assign act = {wait_result, dp_load, dp_step, dp_signed, dp_accum, done, div_zero, count};

    function automatic obs_t mk(input logic w, input logic l, input logic s, input logic sg,
                                input logic [1:0] a, input logic d, input logic z,
                                input int c);
        obs_t o;
        o = {w, l, s, sg, a, d, z, 6'(c)};
        return o;
    endfunction

    // Apply one cycle of inputs just after the rising edge and queue what must be seen.
    task automatic cyc(input logic rst, input logic st, input logic [2:0] fn,
                       input logic dz, input logic clr, input logic hld,
                       input obs_t e, input string n);
        reset        = rst;
        start        = st;
        muldiv_funct = fn;
        divisor_zero = dz;
        clear        = clr;
        hold_result  = hld;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the queued expectation against the DUT mid-cycle.
    initial begin
        obs_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got w=%0b ld=%0b st=%0b sg=%0b acc=%0d dn=%0b dz=%0b cnt=%0d, required w=%0b ld=%0b st=%0b sg=%0b acc=%0d dn=%0b dz=%0b cnt=%0d",
                             n, act.w, act.load, act.step, act.sgn, act.acc, act.dn, act.dz, act.cnt,
                             e.w, e.load, e.step, e.sgn, e.acc, e.dn, e.dz, e.cnt);
                end else begin
                    $display("ok   %s: w=%0b ld=%0b st=%0b sg=%0b acc=%0d dn=%0b dz=%0b cnt=%0d",
                             n, act.w, act.load, act.step, act.sgn, act.acc, act.dn, act.dz, act.cnt);
                end
            end
        end
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        muldiv_funct = F_NONE;
        divisor_zero = 1'b0;
        clear        = 1'b0;
        hold_result  = 1'b0;
        @(posedge clk);
        #1;

        // Held in reset: even a valid start must not produce any strobe.
        cyc(0, 1, F_MULT, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "reset_gate");
        cyc(0, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "reset_idle");

        // Release and accept MULT on the first edge; start kept high while busy.
        cyc(1, 1, F_MULT, 0, 0, 0, mk(1,1,0,0,2'b00,0,0,0), "mult_accept");
        for (int k = 1; k <= 4; k++)
            cyc(1, 1, F_MULT, 0, 0, 0, mk(1,0,1,1,2'b00,0,0,4-k), "mult_step");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,1,2'b00,1,0,0), "mult_done");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,1,2'b00,0,0,0), "mult_idle");

        // DIVU: 32 steps counting 31 down to 0, done on cycle 33, unsigned.
        cyc(1, 1, F_DIVU, 0, 0, 0, mk(1,1,0,1,2'b00,0,0,0), "divu_accept");
        for (int k = 1; k <= 32; k++)
            cyc(1, 0, F_NONE, 0, 0, 0, mk(1,0,1,0,2'b00,0,0,32-k), "divu_step");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,1,0,0), "divu_done");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "divu_idle");

        // DIV by zero: straight to DONE with div_zero, no steps; start in DONE ignored.
        cyc(1, 1, F_DIV, 1, 0, 0, mk(1,1,0,0,2'b00,0,0,0), "divz_accept");
        cyc(1, 1, F_DIV, 1, 0, 0, mk(0,0,0,1,2'b00,1,1,0), "divz_done");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,1,2'b00,0,0,0), "divz_idle");

        // MSUB aborted by clear at step 2; clear also beats a fresh accept.
        cyc(1, 1, F_MSUB, 0, 0, 0, mk(1,1,0,1,2'b00,0,0,0), "msub_accept");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(1,0,1,1,2'b10,0,0,3), "msub_step1");
        cyc(1, 0, F_NONE, 0, 1, 0, mk(0,0,0,1,2'b10,0,0,2), "msub_clear");
        cyc(1, 1, F_MULT, 0, 1, 0, mk(0,0,0,0,2'b00,0,0,0), "clear_over_accept");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "clear_idle");

        // MADD with hold_result: no pause while stepping, done held 4 cycles.
        cyc(1, 1, F_MADD, 0, 0, 1, mk(1,1,0,0,2'b00,0,0,0), "madd_accept");
        for (int k = 1; k <= 4; k++)
            cyc(1, 0, F_NONE, 0, 0, 1, mk(1,0,1,1,2'b01,0,0,4-k), "madd_step");
        for (int k = 0; k < 3; k++)
            cyc(1, 1, F_DIVU, 0, 0, 1, mk(0,0,0,1,2'b01,1,0,0), "madd_hold");
        cyc(1, 1, F_DIVU, 0, 0, 0, mk(0,0,0,1,2'b01,1,0,0), "madd_release");
        cyc(1, 1, F_MULTU, 0, 0, 0, mk(1,1,0,1,2'b01,0,0,0), "multu_accept");
        for (int k = 1; k <= 4; k++)
            cyc(1, 0, F_NONE, 0, 0, 0, mk(1,0,1,0,2'b00,0,0,4-k), "multu_step");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,1,0,0), "multu_done");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "multu_idle");

        // DIV interrupted by reset between edges once count has reached 10.
        cyc(1, 1, F_DIV, 0, 0, 0, mk(1,1,0,0,2'b00,0,0,0), "div_accept");
        for (int k = 1; k <= 21; k++)
            cyc(1, 0, F_NONE, 0, 0, 0, mk(1,0,1,1,2'b00,0,0,32-k), "div_step");
        cyc(0, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "reset_mid_div");
        cyc(0, 1, F_DIV, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "reset_held");
        cyc(1, 1, F_MULTU, 0, 0, 0, mk(1,1,0,0,2'b00,0,0,0), "post_reset_accept");
        for (int k = 1; k <= 4; k++)
            cyc(1, 0, F_NONE, 0, 0, 0, mk(1,0,1,0,2'b00,0,0,4-k), "post_reset_step");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,1,0,0), "post_reset_done");
        cyc(1, 0, F_NONE, 0, 0, 0, mk(0,0,0,0,2'b00,0,0,0), "post_reset_idle");

        // Let the monitor drain the last entry before summarising.
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
